// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the pipelined immediate generator: format select
// encoding, base opcodes and the opcode-driven format decode.
package rv_imm_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_J     = 3'd3,
    IMM_U     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_ZIMM  = 3'd6,
    IMM_RSV   = 3'd7
  } imm_sel_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Map an instruction's opcode (and funct3 where it matters) to a format.
  // Unrecognised opcodes fall onto the reserved select so they flag an error.
  function automatic imm_sel_t auto_sel(input logic [31:0] inst);
    imm_sel_t sel;
    sel = IMM_RSV;
    case (inst[6:0])
      OP_LOAD, OP_JALR, OP_FENCE: sel = IMM_I;
      OP_IMM: begin
        // slli/srli/srai carry a shift amount rather than a 12-bit immediate
        if ((inst[14:12] == 3'b001) || (inst[14:12] == 3'b101)) begin
          sel = IMM_SHAMT;
        end else begin
          sel = IMM_I;
        end
      end
      OP_SYSTEM: begin
        // csrr*i forms put a 5-bit zero-extended immediate in rs1
        if (inst[14]) begin
          sel = IMM_ZIMM;
        end else begin
          sel = IMM_I;
        end
      end
      OP_STORE:         sel = IMM_S;
      OP_BRANCH:        sel = IMM_B;
      OP_JAL:           sel = IMM_J;
      OP_LUI, OP_AUIPC: sel = IMM_U;
      default:          sel = IMM_RSV;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_fmt.sv
// Combinational immediate format mux with optional opcode auto-decode.
import rv_imm_pkg::*;

module imm_fmt #(
  parameter int unsigned XLEN        = XLEN_DEFAULT,
  parameter bit          AUTO_DECODE = 1'b0
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  imm_sel_t sel_s;
  logic     sgn_s;

  assign sgn_s = inst[31];

  // Choose the effective format: decoded from the opcode or taken from sel.
  always_comb begin
    if (AUTO_DECODE) begin
      sel_s = auto_sel(inst);
    end else begin
      sel_s = imm_sel_t'(sel);
    end
  end

  // Assemble the immediate for the selected format at XLEN width.
  always_comb begin
    imm = {XLEN{1'b0}};
    err = 1'b0;
    case (sel_s)
      IMM_I: imm = {{(XLEN-12){sgn_s}}, inst[31:20]};
      IMM_S: imm = {{(XLEN-12){sgn_s}}, inst[31:25], inst[11:7]};
      IMM_B: imm = {{(XLEN-12){sgn_s}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_J: imm = {{(XLEN-20){sgn_s}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      // Bit 31 is the sign; on RV64 it replicates into the upper word.
      IMM_U: imm = {{(XLEN-31){sgn_s}}, inst[30:12], 12'd0};
      // RV32 shift amounts are 5 bits; inst[25] only belongs to shamt on RV64.
      IMM_SHAMT: imm = {{(XLEN-6){1'b0}}, ((XLEN == 32) ? 1'b0 : inst[25]), inst[24:20]};
      IMM_ZIMM:  imm = {{(XLEN-5){1'b0}}, inst[19:15]};
      default: begin
        imm = {XLEN{1'b0}};
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: format logic feeding a registered output
// stage with a one-entry skid register so backpressure never drops a beat.
import rv_imm_pkg::*;

module imm_gen_pipe #(
  parameter int unsigned XLEN        = XLEN_DEFAULT,
  parameter bit          AUTO_DECODE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [2:0]      in_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic            out_err
);

  logic [XLEN-1:0] fmt_imm;
  logic            fmt_err;

  logic            main_valid_d, main_valid_q;
  logic [XLEN-1:0] main_imm_d,   main_imm_q;
  logic            main_err_d,   main_err_q;
  logic            skid_full_d,  skid_full_q;
  logic [XLEN-1:0] skid_imm_d,   skid_imm_q;
  logic            skid_err_d,   skid_err_q;
  logic            in_ready_d,   in_ready_q;

  logic            in_fire;
  logic            out_fire;
  logic            main_free;

  imm_fmt #(
    .XLEN        (XLEN),
    .AUTO_DECODE (AUTO_DECODE)
  ) u_fmt (
    .inst (in_inst),
    .sel  (in_sel),
    .imm  (fmt_imm),
    .err  (fmt_err)
  );

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = main_valid_q & out_ready;
  // Main can take a new beat when empty or when its beat leaves this edge.
  assign main_free = ~main_valid_q | out_fire;

  // Next-state for main/skid: refill main from skid first, else from input;
  // an input arriving while main is stalled parks in skid.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_err_d   = main_err_q;
    skid_full_d  = skid_full_q;
    skid_imm_d   = skid_imm_q;
    skid_err_d   = skid_err_q;
    if (main_free) begin
      if (skid_full_q) begin
        // in_ready was low, so no input can be accepted on this edge
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_err_d   = skid_err_q;
        skid_full_d  = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_imm_d   = fmt_imm;
        main_err_d   = fmt_err;
      end else begin
        main_valid_d = 1'b0;
      end
    end else begin
      if (in_fire) begin
        skid_full_d = 1'b1;
        skid_imm_d  = fmt_imm;
        skid_err_d  = fmt_err;
      end else begin
        skid_full_d = skid_full_q;
      end
    end
    in_ready_d = ~skid_full_d;
  end

  // State registers with synchronous reset discarding any held beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= {XLEN{1'b0}};
      main_err_q   <= 1'b0;
      skid_full_q  <= 1'b0;
      skid_imm_q   <= {XLEN{1'b0}};
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_err_q   <= main_err_d;
      skid_full_q  <= skid_full_d;
      skid_imm_q   <= skid_imm_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_imm   = main_imm_q;
  assign out_err   = main_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV32 manual-select instance and an RV64
// auto-decode instance run in lockstep against a queue-based reference.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_out_err;
  logic [31:0] a_in_inst = 32'd0;
  logic [2:0]  a_in_sel = 3'd0;
  logic [31:0] a_out_imm;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_out_err;
  logic [31:0] b_in_inst = 32'd0;
  logic [2:0]  b_in_sel = 3'd7;
  logic [63:0] b_out_imm;

  int vectors = 0;
  int miscompares = 0;

  // Expected beats held inside each DUT, oldest first: {err, imm64}
  logic [64:0] qa[$];
  logic [64:0] qb[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst), .in_sel(a_in_sel),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm), .out_err(a_out_err)
  );

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst), .in_sel(b_in_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm), .out_err(b_out_err)
  );

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference immediate from the format rules using signed arithmetic.
  function automatic logic [64:0] ref_fmt(input logic [31:0] inst, input int sel, input int xlen);
    longint v;
    logic   e;
    e = 1'b0;
    case (sel)
      0: v = longint'($signed(inst[31:20]));
      1: v = longint'($signed({inst[31:25], inst[11:7]}));
      2: v = longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      3: v = longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      4: v = longint'($signed({inst[31:12], 12'd0}));
      5: v = (xlen == 32) ? longint'(inst[24:20]) : longint'(inst[25:20]);
      6: v = longint'(inst[19:15]);
      default: begin v = 0; e = 1'b1; end
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return {e, 64'(v)};
  endfunction

  function automatic int ref_auto(input logic [31:0] inst);
    logic [2:0] f3;
    f3 = inst[14:12];
    case (inst[6:0])
      7'h03, 7'h67, 7'h0F: return 0;
      7'h13:               return ((f3 == 3'd1) || (f3 == 3'd5)) ? 5 : 0;
      7'h73:               return f3[2] ? 6 : 0;
      7'h23:               return 1;
      7'h63:               return 2;
      7'h6F:               return 3;
      7'h37, 7'h17:        return 4;
      default:             return 7;
    endcase
  endfunction

  task automatic check_outputs();
    chk("a_valid", 65'(a_out_valid), 65'(qa.size() > 0));
    chk("a_ready", 65'(a_in_ready), 65'(qa.size() < 2));
    if (qa.size() > 0) chk("a_data", {a_out_err, 64'(a_out_imm)}, qa[0]);
    chk("b_valid", 65'(b_out_valid), 65'(qb.size() > 0));
    chk("b_ready", 65'(b_in_ready), 65'(qb.size() < 2));
    if (qb.size() > 0) chk("b_data", {b_out_err, b_out_imm}, qb[0]);
  endtask

  // Called at a falling edge: drive, predict the coming rising edge, then check.
  task automatic step(input bit av, input logic [31:0] ai, input logic [2:0] as_,
                      input bit ar, input bit bv, input logic [31:0] bi, input bit br);
    a_in_valid = av; a_in_inst = ai; a_in_sel = as_; a_out_ready = ar;
    b_in_valid = bv; b_in_inst = bi; b_out_ready = br;
    if (a_out_valid && ar) void'(qa.pop_front());
    if (av && a_in_ready)  qa.push_back(ref_fmt(ai, int'(as_), 32));
    if (b_out_valid && br) void'(qb.pop_front());
    if (bv && b_in_ready)  qb.push_back(ref_fmt(bi, ref_auto(bi), 64));
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_a_valid"}, 65'(a_out_valid), 65'd0);
    chk({tag, "_a_ready"}, 65'(a_in_ready), 65'd1);
    chk({tag, "_a_data"}, {a_out_err, 64'(a_out_imm)}, 65'd0);
    chk({tag, "_b_valid"}, 65'(b_out_valid), 65'd0);
    chk({tag, "_b_ready"}, 65'(b_in_ready), 65'd1);
    chk({tag, "_b_data"}, {b_out_err, b_out_imm}, 65'd0);
  endtask

  logic [6:0]  ops [11] = '{7'h03, 7'h67, 7'h0F, 7'h13, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h7F};
  logic [31:0] r_a, r_b;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Single I beat, then back-to-back S/B/J with no bubbles
    step(1'b1, 32'hFFF00093, 3'd0, 1'b1, 1'b1, 32'h800000B7, 1'b1);
    chk("t_i",    {a_out_err, 64'(a_out_imm)}, {1'b0, 64'h0000_0000_FFFF_FFFF});
    chk("t_lui",  {b_out_err, b_out_imm},       {1'b0, 64'hFFFF_FFFF_8000_0000});
    step(1'b1, 32'hFE112E23, 3'd1, 1'b1, 1'b1, 32'h01F0D093, 1'b1);
    chk("t_s",    {a_out_err, 64'(a_out_imm)}, {1'b0, 64'h0000_0000_FFFF_FFFC});
    chk("t_srli", {b_out_err, b_out_imm},       {1'b0, 64'h0000_0000_0000_001F});
    step(1'b1, 32'hFE000CE3, 3'd2, 1'b1, 1'b1, 32'h3402E073, 1'b1);
    chk("t_b",    {a_out_err, 64'(a_out_imm)}, {1'b0, 64'h0000_0000_FFFF_FFF8});
    chk("t_zimm", {b_out_err, b_out_imm},       {1'b0, 64'h0000_0000_0000_0005});
    step(1'b1, 32'h0010006F, 3'd3, 1'b1, 1'b1, 32'h0000007F, 1'b1);
    chk("t_j",    {a_out_err, 64'(a_out_imm)}, {1'b0, 64'h0000_0000_0000_0800});
    chk("t_badop",{b_out_err, b_out_imm},       {1'b1, 64'h0});
    chk("t_j_valid", 65'(a_out_valid), 65'd1);
    step(1'b1, 32'hDEADBEEF, 3'd7, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("t_rsv",  {a_out_err, 64'(a_out_imm)}, {1'b1, 64'h0});
    step(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, 32'd0, 1'b1);

    // Backpressure: beats 1,2 captured, 3 held off by in_ready, order kept
    step(1'b1, 32'h00100093, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 32'h00200093, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("bp_ready_low", 65'(a_in_ready), 65'd0);
    chk("bp_hold1", 65'(a_out_imm), 65'd1);
    step(1'b1, 32'h00300093, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("bp_stable1", 65'(a_out_imm), 65'd1);
    step(1'b1, 32'h00300093, 3'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("bp_order2", 65'(a_out_imm), 65'd2);
    step(1'b1, 32'h00300093, 3'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("bp_order3", 65'(a_out_imm), 65'd3);
    step(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, 32'd0, 1'b1);

    // Reset with main and skid full on both instances
    step(1'b1, 32'h00500093, 3'd0, 1'b0, 1'b1, 32'h00500093, 1'b0);
    step(1'b1, 32'h00600093, 3'd0, 1'b0, 1'b1, 32'h00600093, 1'b0);
    rst = 1'b1;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    qa.delete();
    qb.delete();
    check_reset_state("midrst");
    rst = 1'b0;
    repeat (3) step(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, 32'd0, 1'b1);

    // Randomised traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      r_a = $urandom();
      r_b = $urandom();
      r_b = (r_b & 32'hFFFF_FF80) | {25'd0, ops[$urandom_range(0, 10)]};
      if ($urandom_range(0, 7) == 0) r_b[6:0] = 7'($urandom());
      step($urandom_range(0, 3) != 0, r_a, 3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0, r_b, $urandom_range(0, 2) != 0);
    end
    repeat (4) step(1'b0, 32'd0, 3'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("drain_a", 65'(qa.size()), 65'd0);
    chk("drain_b", 65'(qb.size()), 65'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate generator in the decode stage.
- Takes a full 32-bit instruction and builds the sign- or zero-extended immediate at XLEN width.
- Adds shift-amount and CSR-zimm formats, an optional opcode-driven auto-select mode, and reserved-select error flagging.
- Registered output with a valid/ready handshake and a 2-entry skid buffer, so it sits between fetch/decode and register-read without breaking backpressure.

Parameters:
- XLEN, 32, immediate output width; legal values are 32 and 64.
- AUTO_DECODE, 0, 1 = derive the format from the opcode and ignore in_sel; 0 = use in_sel.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_inst  in  32  full instruction, bits [31:0].
- in_sel  in  3  format select: 0 I, 1 S, 2 B, 3 J, 4 U, 5 SHAMT, 6 ZIMM, 7 reserved.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the output beat.
- out_imm  out  XLEN  generated immediate.
- out_err  out  1  reserved or unknown format; out_imm is 0 for that beat.

Behaviour:
- Transfers: a transfer occurs when valid&ready are both high on a rising edge.
- Format rules (sign bit = inst[31], extended to XLEN):
  - I: inst[31:20], sign-extended.
  - S: {inst[31:25], inst[11:7]}, sign-extended.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.
  - U: {inst[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - SHAMT: zero-extended inst[24:20] for XLEN=32; inst[25:20] for XLEN=64.
  - ZIMM: zero-extended inst[19:15].
  - Select 7: out_imm=0, out_err=1.
- AUTO_DECODE=1 mapping on inst[6:0]:
  - 0000011, 1100111, 0001111, 0010011 → I.
  - Exception: 0010011 with funct3 001 or 101 → SHAMT.
  - 1110011 → I when funct3[2]=0, ZIMM when funct3[2]=1.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111, 0010111 → U.
  - Any other opcode → err path (out_imm=0, out_err=1).
- Datapath: combinational format logic feeds a main output register (out_*) and one skid register.
- Latency: exactly 1 cycle from input transfer to out_valid when the pipe is empty.
- Skid buffer:
  - in_ready is registered and equals !skid_full.
  - If the main register holds an unaccepted beat and in_valid&in_ready, the new beat goes to skid; skid_full is set and in_ready drops next cycle.
  - On an output transfer with skid_full, skid moves to main and skid_full clears.
  - If no skid entry exists, an input accepted on the same edge loads main directly.
- Simultaneous input and output transfer with main full and skid empty: main is replaced by the new beat, out_valid stays 1, no bubble.
- Full throughput: one beat per cycle when out_ready is held high.
- Output stability: out_imm and out_err are held stable while out_valid=1 and out_ready=0.
- Ordering: beats are never dropped, duplicated or reordered.
- Reset values: out_valid=0, out_imm=0, out_err=0, skid_full=0, in_ready=1 in the cycle after rst is sampled high.
- Reset mid-transfer: all held beats are discarded and no output transfer completes on the reset edge.
- Unknown in_sel (X) is not a supported case; when in_valid=0, in_sel is ignored.

Decomposition:
- Shared package rv_imm_pkg holds:
  - the imm_sel_t 3-bit enum (IMM_I..IMM_RSV);
  - opcode constants (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_FENCE);
  - the XLEN default.
- Sub-module imm_fmt: purely combinational format mux plus auto-decode, parametrised by XLEN.
- imm_gen_pipe owns the handshake, main register and skid register.

Test Plan:
- XLEN=32, sel I, inst 0xFFF00093, out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_err=0.
- Back-to-back, out_ready=1:
  - sel S on 0xFE112E23 → 0xFFFFFFFC;
  - sel B on 0xFE000CE3 → 0xFFFFFFF8;
  - sel J on 0x0010006F → 0x00000800;
  - all emitted on consecutive cycles with no bubbles.
- XLEN=64, AUTO_DECODE=1:
  - 0x800000B7 → 0xFFFFFFFF80000000;
  - 0x01F0D093 (srli, shamt 31) → 0x1F;
  - 0x3402E073 (csrrsi, zimm 5) → 0x5;
  - opcode 0x7F → out_imm=0, out_err=1.
- Backpressure: hold out_ready=0 and drive 3 beats →
  - first held stable in main, second in skid;
  - in_ready=0 from the cycle after the second transfer, third held by the source;
  - release out_ready → order 1, 2, 3 preserved.
- sel=7 with any inst → out_imm=0, out_err=1.
- Assert rst with main and skid full → the cycle after reset: out_valid=0, in_ready=1; no stale beat ever appears at the output.
